// File: rtl/neuron_layer_sequencer_pkg.sv
// Shared types and helpers for the fully-connected layer sequencer.
package neuron_layer_sequencer_pkg;

  localparam int DEF_WORD_LENGTH = 16;
  localparam int DEF_FRAC_BITS   = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_ACT   = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Index width for a table of 'depth' entries; never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/neuron_layer_sequencer_if.sv
// Memory read bus and result stream between the sequencer, its memories and the next layer.
interface neuron_layer_sequencer_if #(
  parameter int WORD_LENGTH = 16,
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_NEURONS = 2
) ();
  import neuron_layer_sequencer_pkg::*;

  localparam int XA_W = addr_w(NUM_INPUTS);
  localparam int WA_W = addr_w(NUM_NEURONS * NUM_INPUTS);
  localparam int NA_W = addr_w(NUM_NEURONS);

  logic                          rd_en;
  logic        [XA_W-1:0]        x_addr;
  logic        [WA_W-1:0]        w_addr;
  logic signed [WORD_LENGTH-1:0] x_data;
  logic signed [WORD_LENGTH-1:0] w_data;
  logic                          out_valid;
  logic                          out_ready;
  logic        [NA_W-1:0]        out_addr;
  logic signed [WORD_LENGTH-1:0] out_data;

  modport master (
    output rd_en, x_addr, w_addr, out_valid, out_addr, out_data,
    input  x_data, w_data, out_ready
  );

  modport slave (
    input  rd_en, x_addr, w_addr, out_valid, out_addr, out_data,
    output x_data, w_data, out_ready
  );

endinterface

// File: rtl/neuron_layer_sequencer_mac.sv
// Single signed multiply-accumulate; clear has priority over accumulate.
module neuron_layer_sequencer_mac #(
  parameter int WORD_LENGTH = 16,
  parameter int ACC_W       = 34
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          en,
  input  logic signed [WORD_LENGTH-1:0] a,
  input  logic signed [WORD_LENGTH-1:0] b,
  output logic signed [ACC_W-1:0]       acc
);

  logic signed [2*WORD_LENGTH-1:0] prod;
  logic signed [ACC_W-1:0]         prod_ext;

  assign prod     = a * b;
  assign prod_ext = ACC_W'(prod);

  // Accumulator: full-precision products summed without overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + prod_ext;
  end

endmodule

// File: rtl/neuron_layer_sequencer.sv
// Sequences one fully-connected layer through a shared MAC, then ReLU/saturates each neuron
// result and hands it downstream on a valid/ready port.
module neuron_layer_sequencer
  import neuron_layer_sequencer_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int FRAC_BITS   = DEF_FRAC_BITS,
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_NEURONS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  neuron_layer_sequencer_if.master   bus
);

  localparam int XA_W  = addr_w(NUM_INPUTS);
  localparam int WA_W  = addr_w(NUM_NEURONS * NUM_INPUTS);
  localparam int NA_W  = addr_w(NUM_NEURONS);
  localparam int ACC_W = 2 * WORD_LENGTH + $clog2(NUM_INPUTS);
  localparam logic signed [ACC_W-1:0] RES_MAX =
    {{(ACC_W - WORD_LENGTH + 1){1'b0}}, {(WORD_LENGTH - 1){1'b1}}};

  state_t                        state, state_nx;
  logic        [XA_W-1:0]        i_cnt;
  logic        [NA_W-1:0]        n_cnt;
  logic                          vld_p0;
  logic                          clr;
  logic signed [ACC_W-1:0]       acc;
  logic signed [WORD_LENGTH-1:0] out_data_r;
  logic        [NA_W-1:0]        out_addr_r;
  logic                          last_i, last_n;

  // Rescale the Q-format sum, clamp negatives to zero and positives to the word maximum.
  function automatic logic signed [WORD_LENGTH-1:0] relu_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] res;
    res = a >>> FRAC_BITS;
    if (res[ACC_W-1] || (res == '0)) return '0;
    else if (res > RES_MAX)          return RES_MAX[WORD_LENGTH-1:0];
    else                             return res[WORD_LENGTH-1:0];
  endfunction

  assign last_i = (i_cnt == XA_W'(NUM_INPUTS - 1));
  assign last_n = (n_cnt == NA_W'(NUM_NEURONS - 1));

  assign bus.x_addr   = i_cnt;
  assign bus.w_addr   = WA_W'(int'(n_cnt) * NUM_INPUTS + int'(i_cnt));
  assign bus.out_data = out_data_r;
  assign bus.out_addr = out_addr_r;

  // Accumulator is cleared at layer start and when moving on to the next neuron.
  assign clr = ((state == S_IDLE) && start) ||
               ((state == S_WRITE) && bus.out_ready && !last_n);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; abort from any active state wins over everything else.
  always_comb begin
    state_nx = state;
    if (abort && (state != S_IDLE)) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nx = S_RUN;
        S_RUN:   if (last_i) state_nx = S_DRAIN;
        S_DRAIN: state_nx = S_ACT;
        S_ACT:   state_nx = S_WRITE;
        S_WRITE: if (bus.out_ready) state_nx = last_n ? S_DONE : S_RUN;
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    bus.rd_en     = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      S_RUN:   begin busy = 1'b1; bus.rd_en = 1'b1; end
      S_DRAIN: busy = 1'b1;
      S_ACT:   busy = 1'b1;
      S_WRITE: begin busy = 1'b1; bus.out_valid = 1'b1; end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Input index i and neuron index n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_cnt <= '0;
      n_cnt <= '0;
    end else if (abort && (state != S_IDLE)) begin
      i_cnt <= '0;
      n_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin i_cnt <= '0; n_cnt <= '0; end
        S_RUN:  i_cnt <= last_i ? '0 : i_cnt + 1'b1;
        S_WRITE: if (bus.out_ready) begin
          i_cnt <= '0;
          if (!last_n) n_cnt <= n_cnt + 1'b1;
        end
        S_DONE: n_cnt <= '0;
        default: ;
      endcase
    end
  end

  // ---- p0: memory read latency; data on x_data/w_data is valid when vld_p0 is high ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= bus.rd_en && !abort;
  end

  // ---- p1: multiply-accumulate ----
  neuron_layer_sequencer_mac #(
    .WORD_LENGTH (WORD_LENGTH),
    .ACC_W       (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (vld_p0),
    .a     (bus.x_data),
    .b     (bus.w_data),
    .acc   (acc)
  );

  // ---- p2: activation result register, held through the WRITE stall ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r <= '0;
      out_addr_r <= '0;
    end else if ((state == S_ACT) && !abort) begin
      out_data_r <= relu_sat(acc);
      out_addr_r <= n_cnt;
    end
  end

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Scoreboard bench for neuron_layer_sequencer: reference model per neuron, timing and handshake checks.
module tb_neuron_layer_sequencer;

  localparam int WL = 16;
  localparam int FB = 8;
  localparam int NI = 4;
  localparam int NN = 2;

  typedef struct {
    int          addr;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, start, abort, busy, done;

  neuron_layer_sequencer_if #(.WORD_LENGTH(WL), .NUM_INPUTS(NI), .NUM_NEURONS(NN)) bus ();

  neuron_layer_sequencer #(
    .WORD_LENGTH (WL),
    .FRAC_BITS   (FB),
    .NUM_INPUTS  (NI),
    .NUM_NEURONS (NN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic signed [WL-1:0] x_mem [NI];
  logic signed [WL-1:0] w_mem [NI*NN];

  // Synchronous memories: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.x_data <= x_mem[bus.x_addr];
      bus.w_data <= w_mem[bus.w_addr];
    end
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   start_cyc, first_valid_cyc, done_cyc;
  int   done_cnt  = 0;
  int   valid_cnt = 0;
  int   hs_cycs[$];
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model(input int n);
    longint acc;
    acc = 0;
    for (int i = 0; i < NI; i++)
      acc += longint'(x_mem[i]) * longint'(w_mem[n*NI + i]);
    acc = acc >>> FB;
    if (acc <= 0) return 16'h0000;
    if (acc > 32767) return 16'h7FFF;
    return acc[15:0];
  endfunction

  // Monitor: scoreboard pops, stall stability, rd_en exclusivity, done accounting.
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [15:0] prev_data;
  int          prev_addr;
  always @(negedge clk) begin
    if (bus.out_valid) begin
      valid_cnt++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      check("rd_en_in_write", 32'(bus.rd_en), 0);
      if (prev_valid && !prev_ready) begin
        check("stall_data", 32'(bus.out_data), 32'(prev_data));
        check("stall_addr", 32'(bus.out_addr), prev_addr);
      end
      if (bus.out_ready) begin
        hs_cycs.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_addr", 32'(bus.out_addr), e.addr);
          check("out_data", 32'(bus.out_data), 32'(e.data));
        end
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("busy_at_done", 32'(busy), 0);
    end
    prev_valid = bus.out_valid;
    prev_ready = bus.out_ready;
    prev_data  = bus.out_data;
    prev_addr  = int'(bus.out_addr);
  end

  task automatic load(input logic [15:0] xv, input logic [15:0] w0, input logic [15:0] w1);
    for (int i = 0; i < NI; i++) begin
      x_mem[i]      = xv;
      w_mem[i]      = w0;
      w_mem[NI + i] = w1;
    end
  endtask

  task automatic run_layer();
    for (int n = 0; n < NN; n++) begin
      exp_t e;
      e.addr = n;
      e.data = model(n);
      sb.push_back(e);
    end
    first_valid_cyc = -1;
    hs_cycs.delete();
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < lim) begin tick(); k++; end
    if (done_cnt == d0) check("done_timeout", 0, 1);
  endtask

  task automatic wait_valid(input int lim);
    int k;
    k = 0;
    while (!bus.out_valid && k < lim) begin tick(); k++; end
    if (!bus.out_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic check_timing(input int stall);
    check("lat_first", first_valid_cyc - start_cyc, NI + 3);
    check("hs_count", hs_cycs.size(), NN);
    if (hs_cycs.size() == NN)
      check("lat_n1", hs_cycs[1] - hs_cycs[0], NI + 3);
    check("lat_done", done_cyc - start_cyc, NN * (NI + 3) + 1 + stall);
    check("sb_empty", sb.size(), 0);
    check("busy_after", 32'(busy), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_rd_en"}, 32'(bus.rd_en), 0);
    check({tag, "_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_data"},  32'(bus.out_data), 0);
    check({tag, "_oaddr"}, 32'(bus.out_addr), 0);
    check({tag, "_xaddr"}, 32'(bus.x_addr), 0);
    check({tag, "_waddr"}, 32'(bus.w_addr), 0);
  endtask

  initial begin
    int d0, v0;
    rst_n         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    bus.out_ready = 1'b1;
    bus.x_data    = '0;
    bus.w_data    = '0;
    first_valid_cyc = -1;
    load(16'h0100, 16'h0080, 16'h0080);
    repeat (3) tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Basic pass: 1.0 * 0.5 summed four times -> 2.0 for both neurons.
    run_layer();
    wait_done(60);
    check_timing(0);
    tick();

    // Negative sum clamps to zero, positive passes through.
    load(16'h0100, 16'hFF80, 16'h0080);
    run_layer();
    wait_done(60);
    check_timing(0);
    tick();

    // Positive saturation.
    load(16'h7F00, 16'h7F00, 16'h7F00);
    run_layer();
    wait_done(60);
    check_timing(0);
    tick();

    // Five-cycle back-pressure on the first result.
    load(16'h0100, 16'h0080, 16'h0080);
    run_layer();
    wait_valid(30);
    bus.out_ready = 1'b0;
    repeat (5) tick();
    bus.out_ready = 1'b1;
    wait_done(60);
    check_timing(5);
    tick();

    // Abort in the second RUN cycle: nothing emitted, no done.
    d0 = done_cnt;
    v0 = valid_cnt;
    run_layer();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sb.delete();
    check("abort_busy", 32'(busy), 0);
    check("abort_rd_en", 32'(bus.rd_en), 0);
    repeat (15) tick();
    check("abort_no_valid", valid_cnt - v0, 0);
    check("abort_no_done", done_cnt - d0, 0);
    run_layer();
    wait_done(60);
    check_timing(0);
    tick();

    // Start pulse while busy is ignored; async reset during WRITE clears everything.
    run_layer();
    repeat (2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(30);
    check("ignored_start_lat", first_valid_cyc < 0 ? cyc - start_cyc : first_valid_cyc - start_cyc, NI + 3);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();

    // Recovery after reset.
    load(16'h0100, 16'hFF80, 16'h0080);
    run_layer();
    wait_done(60);
    check_timing(0);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
